// File: rtl/hopfield_recall_pkg.sv
// Shared definitions for the Hopfield recall block.
//   N        : neuron count (weight matrix is N x N)
//   IdxW     : width of the neuron index
//   CntW     : width of the per-neuron match count
//   SwCntW   : width of the sweep counter / SweepCount output
//   MatchThr : minimum off-diagonal matches for a neuron to fire (+1)
//   state_e  : recall FSM states
package hopfield_recall_pkg;

   localparam int unsigned N      = 10;
   localparam int unsigned IdxW   = $clog2(N);
   localparam int unsigned CntW   = 4;
   localparam int unsigned SwCntW = 4;

   // N-1 = 9 voting terms, so a threshold of 5 is a strict majority with no tie.
   localparam logic [CntW-1:0] MatchThr = CntW'(5);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StUpdate,
      StCheck,
      StDone
   } state_e;

endpackage

// File: rtl/hopfield_recall_if.sv
// Request/result bundle for hopfield_recall.
//   Start      : request recall of Pattern (master -> slave)
//   Pattern    : probe pattern, bit 1 = +1, bit 0 = -1
//   Weight     : N x N weight matrix, Weight[i][j] is from neuron j into neuron i
//   Busy       : recall in progress (slave -> master)
//   Done       : single-cycle pulse, Result/Converged/SweepCount valid
//   Result     : recalled state
//   Converged  : final sweep changed no bit
//   SweepCount : number of sweeps executed
interface hopfield_recall_if;
   import hopfield_recall_pkg::*;

   logic              Start;
   logic [0:N-1]      Pattern;
   logic              Weight [0:N-1][0:N-1];
   logic              Busy;
   logic              Done;
   logic [0:N-1]      Result;
   logic              Converged;
   logic [SwCntW-1:0] SweepCount;

   modport master (
      output Start, Pattern, Weight,
      input  Busy, Done, Result, Converged, SweepCount
   );

   modport slave (
      input  Start, Pattern, Weight,
      output Busy, Done, Result, Converged, SweepCount
   );

endinterface

// File: rtl/hopfield_recall_neuron_match_count.sv
// Combinational match counter for one neuron.
//   row_i   : weight row of the neuron being updated
//   state_i : current network state
//   idx_i   : index of the neuron being updated (its diagonal term is skipped)
//   count_o : number of j != idx_i with XNOR(row_i[j], state_i[j]) = 1
module neuron_match_count
   import hopfield_recall_pkg::*;
(
   input  logic [0:N-1]    row_i,
   input  logic [0:N-1]    state_i,
   input  logic [IdxW-1:0] idx_i,
   output logic [CntW-1:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int j = 0; j < N; j++) begin
         if ((j != int'(idx_i)) && (row_i[j] ~^ state_i[j])) begin
            count_o = count_o + CntW'(1);
         end
      end
   end

endmodule

// File: rtl/hopfield_recall.sv
// Hopfield network recall engine with sequential (asynchronous) neuron updates.
//   Clock   : system clock, rising edge
//   Reset_n : synchronous active-low reset
//   bus     : slave side of hopfield_recall_if (Start/Pattern/Weight in,
//             Busy/Done/Result/Converged/SweepCount out)
// Parameter MAX_SWEEPS (1..15) bounds the number of full update sweeps.
module hopfield_recall
   import hopfield_recall_pkg::*;
#(
   parameter int unsigned MAX_SWEEPS = 8
) (
   input logic              Clock,
   input logic              Reset_n,
   hopfield_recall_if.slave bus
);

   state_e              state_q, state_d;
   logic [0:N-1]        s_q, s_d;
   logic [0:N-1]        w_q [0:N-1];
   logic [0:N-1]        w_d [0:N-1];
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [SwCntW-1:0]   sweep_q, sweep_d;
   logic                chg_q, chg_d;
   logic [0:N-1]        result_q, result_d;
   logic                conv_q, conv_d;
   logic [SwCntW-1:0]   swc_q, swc_d;

   logic [CntW-1:0]     match_cnt;
   logic                new_bit;

   neuron_match_count u_match (
      .row_i   (w_q[idx_q]),
      .state_i (s_q),
      .idx_i   (idx_q),
      .count_o (match_cnt)
   );

   assign new_bit = (match_cnt >= MatchThr);

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      w_d      = w_q;
      idx_d    = idx_q;
      sweep_d  = sweep_q;
      chg_d    = chg_q;
      result_d = result_q;
      conv_d   = conv_q;
      swc_d    = swc_q;

      unique case (state_q)
         StIdle: begin
            if (bus.Start) state_d = StLoad;
         end
         StLoad: begin
            // Snapshot inputs so later changes cannot disturb the running recall.
            s_d = bus.Pattern;
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) begin
                  w_d[i][j] = bus.Weight[i][j];
               end
            end
            idx_d   = '0;
            sweep_d = '0;
            chg_d   = 1'b0;
            state_d = StUpdate;
         end
         StUpdate: begin
            // Written in place: the next neuron sees this sweep's new value.
            s_d[idx_q] = new_bit;
            if (new_bit != s_q[idx_q]) chg_d = 1'b1;
            if (idx_q == IdxW'(N - 1)) begin
               state_d = StCheck;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         StCheck: begin
            sweep_d = sweep_q + SwCntW'(1);
            if (!chg_q) begin
               state_d  = StDone;
               conv_d   = 1'b1;
               result_d = s_q;
               swc_d    = sweep_d;
            end else if (sweep_d == SwCntW'(MAX_SWEEPS)) begin
               state_d  = StDone;
               conv_d   = 1'b0;
               result_d = s_q;
               swc_d    = sweep_d;
            end else begin
               chg_d   = 1'b0;
               idx_d   = '0;
               state_d = StUpdate;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_q  <= StIdle;
         s_q      <= '0;
         for (int i = 0; i < N; i++) begin
            w_q[i] <= '0;
         end
         idx_q    <= '0;
         sweep_q  <= '0;
         chg_q    <= 1'b0;
         result_q <= '0;
         conv_q   <= 1'b0;
         swc_q    <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         w_q      <= w_d;
         idx_q    <= idx_d;
         sweep_q  <= sweep_d;
         chg_q    <= chg_d;
         result_q <= result_d;
         conv_q   <= conv_d;
         swc_q    <= swc_d;
      end
   end

   assign bus.Busy       = (state_q == StLoad) || (state_q == StUpdate) || (state_q == StCheck);
   assign bus.Done       = (state_q == StDone);
   assign bus.Result     = result_q;
   assign bus.Converged  = conv_q;
   assign bus.SweepCount = swc_q;

endmodule

// File: doc/hopfield_recall.md
HOPFIELD_RECALL -- requirements
Module: hopfield_recall

Interface
REQ-001 Parameter: N, 10, neuron count; equals weight-matrix dimension.
REQ-002 Parameter: MAX_SWEEPS, 8, maximum full update sweeps before forced termination (range 1..15).
REQ-003 Port: Clock  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: Reset_n  input  1  reset; synchronous, active-low.
REQ-005 Port: Start  input  1  request recall of Pattern; sampled only in IDLE.
REQ-006 Port: Pattern  input  [0:N-1]  probe pattern; bit 1 = +1, bit 0 = -1.
REQ-007 Port: Weight  input  [0:N-1] x [0:N-1] unpacked array  weight matrix from the weight-initialise stage; bit 1 = +1, bit 0 = -1; Weight[i][j] = weight from neuron j into neuron i.
REQ-008 Port: Busy  output  1  high from the cycle after Start is accepted through CHECK of the final sweep.
REQ-009 Port: Done  output  1  single-cycle pulse when Result is valid.
REQ-010 Port: Result  output  [0:N-1]  recalled state; held stable from Done until the next accepted Start.
REQ-011 Port: Converged  output  1  1 = final sweep changed no bit; 0 = terminated by MAX_SWEEPS; valid with Done and held.
REQ-012 Port: SweepCount  output  4  number of sweeps executed; valid with Done and held.

Function
REQ-013 States SHALL be IDLE, LOAD, UPDATE, CHECK, DONE.
REQ-014 IDLE: Start=1 -> LOAD; Start ignored in every other state.
REQ-015 LOAD (1 cycle): snapshot Pattern into state register and Weight into a local N x N register; clear neuron index, sweep counter and change flag; -> UPDATE.
REQ-016 Weight or Pattern changes after LOAD SHALL NOT affect the running recall.
REQ-017 UPDATE: one neuron i per cycle, i = 0..N-1 in order; matches = count of j != i where XNOR(W[i][j], s[j]) = 1; new s[i] = 1 if matches >= 5, else 0 (N-1 = 9 terms, no tie possible).
REQ-018 Updates SHALL be sequential (asynchronous Hopfield): neuron i sees values of neurons < i written in the same sweep.
REQ-019 Diagonal Weight[i][i] SHALL be ignored.
REQ-020 Change flag SHALL be set if any new s[i] differs from old s[i] within the sweep.
REQ-021 After i = N-1 -> CHECK (1 cycle): increment sweep counter; if change flag = 0 -> DONE with Converged=1; else if sweep counter = MAX_SWEEPS -> DONE with Converged=0; else clear flag, i=0, -> UPDATE.
REQ-022 DONE (1 cycle): Done=1, Result/Converged/SweepCount registered; -> IDLE.
REQ-023 Latency: Start sampled at cycle t -> Done high in cycle t + 2 + 11*S, S = sweeps executed.
REQ-024 Back-to-back: Start asserted in the cycle after Done SHALL be accepted.

Reset
REQ-025 Reset_n=0 at a rising edge SHALL force IDLE and Busy=0, Done=0, Result=0, Converged=0, SweepCount=0, internal state/index/counters=0.
REQ-026 Reset mid-operation SHALL abort the recall with no Done pulse.
REQ-027 Reset SHALL take priority over Start in the same cycle.

Structure
REQ-028 Shared package SHALL hold N, the match threshold (5), the state enum type and the SweepCount width.
REQ-029 One sub-module SHALL be used: neuron_match_count (combinational XNOR-popcount of row i vs state excluding diagonal, 4-bit output).
REQ-030 RTL SHALL be one FSM plus datapath, 120-400 lines total.

Verification
REQ-031 All Weight=1, Pattern=0000000000, Start at t -> Done at t+13, Result=0000000000, Converged=1, SweepCount=1.
REQ-032 All Weight=1, Pattern=1111100000 -> Done at t+24, Result=0000000000, Converged=1, SweepCount=2; Pattern=1111110000 -> Result=1111111111, SweepCount=2.
REQ-033 All Weight=0, Pattern=0000000000 -> Result=1111100000, Converged=1, SweepCount=2, Done at t+24.
REQ-034 MAX_SWEEPS=1, all Weight=1, Pattern=1111100000 -> Done at t+13, Result=0000000000, Converged=0, SweepCount=1.
REQ-035 Start during Busy plus Weight/Pattern toggled mid-run -> ignored; Result equals the undisturbed run; exactly one Done.
REQ-036 Reset_n=0 for 1 cycle during UPDATE of sweep 1 -> next cycle IDLE, all outputs 0, no Done; subsequent Start completes normally.
